// File: rtl/sga_interface_direcao_if.sv
// sga_interface_direcao_if: control-unit <-> sensor-interface bundle.
// master: medir, reset_interface, enable_interface and the echo pins.
// slave: triggers, interface_direction, fim_inter, db_state.
// With SGA_INTER_DIST_EN defined it also carries dist_dir/dist_esq (CW bits).
interface sga_interface_direcao_if
`ifdef SGA_INTER_DIST_EN
  #(parameter int CW = 24)
`endif
  ;
  logic medir;
  logic reset_interface;
  logic enable_interface;
  logic echo_dir;
  logic echo_esq;
  logic trigger_dir;
  logic trigger_esq;
  logic [1:0] interface_direction;
  logic fim_inter;
  logic [3:0] db_state;
`ifdef SGA_INTER_DIST_EN
  logic [CW-1:0] dist_dir;
  logic [CW-1:0] dist_esq;
`endif
  modport master(
    output medir, reset_interface, enable_interface, echo_dir, echo_esq,
    input trigger_dir, trigger_esq, interface_direction, fim_inter, db_state
`ifdef SGA_INTER_DIST_EN
    , input dist_dir, dist_esq
`endif
  );
  modport slave(
    input medir, reset_interface, enable_interface, echo_dir, echo_esq,
    output trigger_dir, trigger_esq, interface_direction, fim_inter, db_state
`ifdef SGA_INTER_DIST_EN
    , output dist_dir, dist_esq
`endif
  );
endinterface

// File: rtl/sga_interface_direcao.sv
// sga_interface_direcao: sequential right/left ultrasonic measurement producing {near_dir, near_esq}.
// Ports: clock, reset (sync, active high), bus (slave modport of sga_interface_direcao_if).
// Optional: SGA_INTER_DIST_EN adds dist_dir/dist_esq holding the last echo widths.
module sga_interface_direcao #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int NEAR_CYCLES    = 29000,
  parameter int CW             = 24
) (
  input logic clock,
  input logic reset,
  sga_interface_direcao_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, TRIG_DIR, WAIT_DIR, MEAS_DIR, TRIG_ESQ, WAIT_ESQ, MEAS_ESQ, DONE
  } state_t;
  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] NEAR      = CW'(NEAR_CYCLES);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] sync_dir, sync_esq;
  logic near_dir, near_esq, near_dir_d, near_esq_d;
  logic [1:0] direction;
  logic echo, finish, near_v, esq_side;
`ifdef SGA_INTER_DIST_EN
  logic [CW-1:0] dist_dir, dist_esq, dist_v;
`endif
  // State bit 2 marks the left-sensor half of the sequence (DONE never finishes a sensor).
  assign esq_side = state[2];
  assign echo = esq_side ? sync_esq[1] : sync_dir[1];
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    finish  = 1'b0;
    near_v  = 1'b0;
`ifdef SGA_INTER_DIST_EN
    dist_v  = TIMEOUT;
`endif
    case (state)
      IDLE, DONE: begin
        state_d = bus.medir ? TRIG_DIR : state;
        cnt_d   = bus.medir ? '0 : cnt;
      end
      TRIG_DIR, TRIG_ESQ: begin
        state_d = cnt == TRIG_LAST ? state_t'(state + 3'd1) : state;
        cnt_d   = cnt == TRIG_LAST ? '0 : cnt + CW'(1);
      end
      WAIT_DIR, WAIT_ESQ: begin
        // A missing echo skips MEAS and goes straight to the next sensor (or DONE).
        finish  = !echo && cnt == TIMEOUT;
        state_d = echo ? state_t'(state + 3'd1) : finish ? state_t'(state + 3'd2) : state;
        cnt_d   = echo ? CW'(1) : finish ? '0 : cnt + CW'(1);
      end
      MEAS_DIR, MEAS_ESQ: begin
        finish  = !echo || cnt == TIMEOUT;
        near_v  = !echo && cnt < NEAR;
`ifdef SGA_INTER_DIST_EN
        dist_v  = echo ? TIMEOUT : cnt;
`endif
        state_d = finish ? state_t'(state + 3'd1) : state;
        cnt_d   = finish ? '0 : cnt + CW'(1);
      end
    endcase
    near_dir_d = finish && !esq_side ? near_v : near_dir;
    near_esq_d = finish && esq_side ? near_v : near_esq;
  end
  always_ff @(posedge clock) begin
    sync_dir <= reset ? 2'b00 : {sync_dir[0], bus.echo_dir};
    sync_esq <= reset ? 2'b00 : {sync_esq[0], bus.echo_esq};
    if (reset || bus.reset_interface) begin
      state    <= IDLE;
      cnt      <= '0;
      near_dir <= 1'b0;
      near_esq <= 1'b0;
`ifdef SGA_INTER_DIST_EN
      dist_dir <= '0;
      dist_esq <= '0;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      near_dir <= near_dir_d;
      near_esq <= near_esq_d;
`ifdef SGA_INTER_DIST_EN
      dist_dir <= finish && !esq_side ? dist_v : dist_dir;
      dist_esq <= finish && esq_side ? dist_v : dist_esq;
`endif
    end
    // The committed direction survives reset_interface; only a full reset clears it.
    if (reset)
      direction <= 2'b00;
    else if (bus.enable_interface && !bus.reset_interface)
      direction <= {near_dir, near_esq};
  end
  assign bus.trigger_dir         = state == TRIG_DIR;
  assign bus.trigger_esq         = state == TRIG_ESQ;
  assign bus.fim_inter           = state == DONE;
  assign bus.db_state            = {1'b0, state};
  assign bus.interface_direction = direction;
`ifdef SGA_INTER_DIST_EN
  assign bus.dist_dir = dist_dir;
  assign bus.dist_esq = dist_esq;
`endif
endmodule

// File: tb/tb_sga_interface_direcao.sv
// tb_sga_interface_direcao: table-driven check of sga_interface_direcao with small timing parameters.
module tb_sga_interface_direcao;
  localparam int T = 4;
  localparam int TO = 200;
  typedef struct {
    int wd;
    int we;
    logic [1:0] exp;
  } vec_t;
  logic clk, rst;
  int errors = 0;
  int checks = 0;
  int w_dir_cfg = -1;
  int w_esq_cfg = -1;
  int rem_d = 0, rem_e = 0, hi_d = 0, hi_e = 0;
  logic prev_td = 1'b0, prev_te = 1'b0;
`ifdef SGA_INTER_DIST_EN
  sga_interface_direcao_if #(.CW(24)) bus();
`else
  sga_interface_direcao_if bus();
`endif
  sga_interface_direcao #(
    .TRIG_CYCLES(T), .TIMEOUT_CYCLES(TO), .NEAR_CYCLES(50), .CW(24)
  ) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Sensor models: an echo of the configured width starts as soon as the trigger falls.
  always @(negedge clk) begin
    if (prev_td && !bus.trigger_dir) begin
      chk("trig_dir_width", hi_d, T);
      rem_d = w_dir_cfg;
    end
    hi_d = bus.trigger_dir ? hi_d + 1 : 0;
    prev_td = bus.trigger_dir;
    bus.echo_dir = rem_d > 0;
    if (rem_d > 0) rem_d--;
  end
  always @(negedge clk) begin
    if (prev_te && !bus.trigger_esq) begin
      chk("trig_esq_width", hi_e, T);
      rem_e = w_esq_cfg;
    end
    hi_e = bus.trigger_esq ? hi_e + 1 : 0;
    prev_te = bus.trigger_esq;
    bus.echo_esq = rem_e > 0;
    if (rem_e > 0) rem_e--;
  end
  always @(negedge clk)
    if (bus.trigger_dir || bus.trigger_esq)
      chk("one_trigger", longint'(bus.trigger_dir && bus.trigger_esq), 0);
  task automatic pulse_medir();
    bus.medir = 1'b1;
    @(negedge clk);
    bus.medir = 1'b0;
  endtask
  task automatic pulse_enable();
    bus.enable_interface = 1'b1;
    @(negedge clk);
    bus.enable_interface = 1'b0;
  endtask
  task automatic wait_state(input logic [3:0] s, input string nm);
    int n = 0;
    while (bus.db_state != s && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.db_state, s);
  endtask
  task automatic wait_quiet();
    int n = 0;
    while ((bus.echo_dir || bus.echo_esq) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("echo_quiet", longint'(bus.echo_dir || bus.echo_esq), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic run(input int wd, input int we, input logic [1:0] exp);
    int cyc = 1;
    int lat;
    w_dir_cfg = wd;
    w_esq_cfg = we;
    pulse_medir();
    chk("start_state", bus.db_state, 1);
    chk("start_trig_esq", bus.trigger_esq, 0);
    while (!bus.fim_inter && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("fim_inter", bus.fim_inter, 1);
    chk("done_state", bus.db_state, 7);
    if (wd > 0 && wd < TO && we > 0 && we < TO) begin
      lat = (T + 2 + wd + 1) + (T + 2 + we + 1) + 1;
      chk("latency_in_window", longint'(cyc >= lat - 2 && cyc <= lat + 2), 1);
    end
    pulse_enable();
    chk("direction", bus.interface_direction, exp);
`ifdef SGA_INTER_DIST_EN
    chk("dist_dir", bus.dist_dir, (wd <= 0 || wd >= TO) ? TO : wd);
    chk("dist_esq", bus.dist_esq, (we <= 0 || we >= TO) ? TO : we);
`endif
    wait_quiet();
  endtask
  vec_t vecs[7];
  initial begin
    vecs[0] = '{wd: 20,  we: 100, exp: 2'b10};
    vecs[1] = '{wd: -1,  we: -1,  exp: 2'b00};
    vecs[2] = '{wd: 49,  we: 49,  exp: 2'b11};
    vecs[3] = '{wd: 50,  we: 50,  exp: 2'b00};
    vecs[4] = '{wd: 500, we: 500, exp: 2'b00};
    vecs[5] = '{wd: 10,  we: 30,  exp: 2'b11};
    vecs[6] = '{wd: 60,  we: 5,   exp: 2'b01};
    rst = 1'b1;
    bus.medir = 1'b0;
    bus.reset_interface = 1'b0;
    bus.enable_interface = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_trig_dir", bus.trigger_dir, 0);
    chk("rst_trig_esq", bus.trigger_esq, 0);
    chk("rst_fim", bus.fim_inter, 0);
    chk("rst_state", bus.db_state, 0);
    chk("rst_direction", bus.interface_direction, 0);
    pulse_enable();
    chk("enable_after_rst", bus.interface_direction, 0);
    for (int i = 0; i < 7; i++) run(vecs[i].wd, vecs[i].we, vecs[i].exp);
    // Abort during MEAS_DIR: results and FSM clear, committed direction stays.
    w_dir_cfg = 100;
    w_esq_cfg = 10;
    pulse_medir();
    wait_state(4'd3, "reach_meas_dir");
    repeat (3) @(negedge clk);
    bus.reset_interface = 1'b1;
    @(negedge clk);
    bus.reset_interface = 1'b0;
    chk("abort_trig_dir", bus.trigger_dir, 0);
    chk("abort_trig_esq", bus.trigger_esq, 0);
    chk("abort_state", bus.db_state, 0);
    chk("abort_fim", bus.fim_inter, 0);
    chk("abort_direction_kept", bus.interface_direction, 2'b01);
    repeat (4) @(negedge clk);
    chk("abort_stays_idle", bus.db_state, 0);
    pulse_enable();
    chk("abort_flags_cleared", bus.interface_direction, 0);
    wait_quiet();
    run(20, 100, 2'b10);
    // medir ignored mid-measurement, restarts from DONE.
    w_dir_cfg = 10;
    w_esq_cfg = 60;
    pulse_medir();
    wait_state(4'd6, "reach_meas_esq");
    pulse_medir();
    chk("medir_ignored", bus.db_state, 6);
    wait_state(4'd7, "reach_done");
    chk("done_fim", bus.fim_inter, 1);
    pulse_medir();
    chk("restart_fim_drop", bus.fim_inter, 0);
    chk("restart_trig_dir", bus.trigger_dir, 1);
    chk("restart_state", bus.db_state, 1);
    wait_state(4'd7, "restart_done");
    pulse_enable();
    chk("restart_direction", bus.interface_direction, 2'b10);
    wait_quiet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sga_interface_direcao.md
Name: sga_interface_direcao

Overview:
- Upstream stage of the Snake Game Arcade control unit: measures two ultrasonic sensors (right "dir", left "esq") and produces the 2-bit turn request `interface_direction = {dir, esq}` plus the `fim_inter` done flag.
- The control unit drives `medir`, `reset_interface` and `enable_interface`, then consumes `fim_inter` and `interface_direction`.
- Sensors are measured sequentially so that one sensor's echo cannot corrupt the other.

Parameters:
- TRIG_CYCLES, 500: trigger pulse width in clocks (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000: maximum wait for echo rise, and maximum echo width (30 ms).
- NEAR_CYCLES, 29000: an echo width strictly below this counts as "hand near" (about 10 cm).
- CW, 24: width of the internal counters; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- medir  in  1  start-measurement request (1-cycle pulse or level).
- reset_interface  in  1  synchronous clear of results, FSM and fim_inter.
- enable_interface  in  1  commits the measured result to interface_direction.
- echo_dir  in  1  right sensor echo (asynchronous).
- echo_esq  in  1  left sensor echo (asynchronous).
- trigger_dir  out  1  right sensor trigger.
- trigger_esq  out  1  left sensor trigger.
- interface_direction  out  2  committed result: bit1 = right near, bit0 = left near.
- fim_inter  out  1  measurement complete.
- db_state  out  4  current FSM state encoding.

Behaviour:
- Reset value of every output is 0. The FSM returns to IDLE and all counters and near flags clear.
- reset_interface has the same effect as reset, except that interface_direction keeps its value.
- If reset or reset_interface is asserted mid-measurement, the measurement aborts and the trigger drops on the next edge.
- Echo synchronisation:
  - Each echo passes through a 2-flop synchroniser, so internal echo lags the pin by 2 clocks.
  - Only the synchronised echo is used anywhere.
- FSM states and encodings:
  - IDLE(0): if medir, go to TRIG_DIR and clear the counter.
  - TRIG_DIR(1): trigger_dir=1 for exactly TRIG_CYCLES clocks, then go to WAIT_DIR with the counter cleared.
  - WAIT_DIR(2):
    - Synced echo_dir=1 → MEAS_DIR, counter=1.
    - Counter reaches TIMEOUT_CYCLES → near_dir=0, go to TRIG_ESQ.
  - MEAS_DIR(3):
    - Count while echo is high.
    - On echo fall: near_dir = (count < NEAR_CYCLES), go to TRIG_ESQ.
    - Count reaches TIMEOUT_CYCLES: near_dir=0, go to TRIG_ESQ.
  - TRIG_ESQ(4), WAIT_ESQ(5), MEAS_ESQ(6): identical to the right-sensor states, for the left sensor.
  - DONE(7):
    - fim_inter=1, held as a level until a new medir, reset_interface or reset.
    - medir in DONE starts a new measurement (go to TRIG_DIR), and fim_inter drops the next cycle.
- medir is ignored in every state other than IDLE and DONE.
- enable_interface:
  - Sampled in any state; interface_direction <= {near_dir, near_esq} on the next edge.
  - Outside DONE it commits the last completed flags (0 after reset).
- Counters saturate at TIMEOUT_CYCLES and never wrap.
- Minimum latency from medir to fim_inter, with an immediate echo of width W on both sensors: 2*(TRIG_CYCLES + 2 + W + 1) + 1 clocks. The bench checks within ±2.
- Only one trigger is high at a time. Both triggers are 0 outside the TRIG states.

Optional Feature:
- SGA_INTER_DIST_EN defined:
  - Adds outputs dist_dir and dist_esq, each CW bits.
  - Each holds the last measured echo width for its sensor, captured on echo fall.
  - A timeout loads TIMEOUT_CYCLES.
  - Reset and reset_interface clear them.
- Not defined: the ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
Bench parameters: TRIG_CYCLES=4, TIMEOUT_CYCLES=200, NEAR_CYCLES=50.
1. Pulse medir; echo_dir high 20 clks, echo_esq high 100 clks; pulse enable_interface after fim_inter → each trigger high exactly 4 clks, right before left; interface_direction=2'b10.
2. Both echoes never rise → each WAIT state times out at 200; fim_inter=1; after enable, interface_direction=2'b00. With SGA_INTER_DIST_EN: dist_dir=dist_esq=200.
3. Both echoes 49 clks, then rerun with both at 50 → first run gives 2'b11, second gives 2'b00 (boundary is strict less-than).
4. Echo stuck high 500 clks → saturates at 200, near=0, FSM reaches DONE, and the counter does not wrap.
5. Assert reset_interface during MEAS_DIR → trigger low, db_state=0, fim_inter=0, interface_direction unchanged; a following medir runs a full measurement.
6. Second medir while in MEAS_ESQ → ignored. Once in DONE, medir restarts the measurement: fim_inter drops next cycle and trigger_dir rises.
